// File: rtl/uart_tx_queue_pkg.sv
// uart_tx_queue_pkg
//   Shared constants and types for the uart transmit queue.
//   - WORD_LEN             : width of the uart bus data/address words
//   - UART_THR_ADDR/LSR    : uart register map (transmit holding, line status)
//   - LSR_*_BIT            : line status register bit indices
//   - tx_state_e           : drain FSM state encoding
package uart_tx_queue_pkg;

    localparam int WORD_LEN = 32;

    localparam logic [WORD_LEN-1:0] UART_THR_ADDR = 32'h0000_0000;
    localparam logic [WORD_LEN-1:0] UART_LSR_ADDR = 32'h0000_0014;

    localparam int LSR_DR_BIT   = 0;
    localparam int LSR_THRE_BIT = 5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_POLL_A = 3'd1,
        ST_POLL_C = 3'd2,
        ST_WRITE  = 3'd3,
        ST_SETTLE = 3'd4
    } tx_state_e;

endpackage

// File: rtl/uart_tx_queue_sync_fifo.sv
// uart_tx_queue_sync_fifo
//   Single-clock FIFO with flush; reusable for a receive-side queue.
//   Ports:
//     clk, rst   : clock, asynchronous active-high reset
//     push       : write push_data (ignored when full or flushing)
//     push_data  : byte to store
//     pop        : drop the head entry (ignored when empty or flushing)
//     flush      : discard all entries
//     head       : entry at the read pointer
//     level      : number of stored entries (one extra bit so full != empty)
//     empty/full : level == 0 / level == DEPTH
module uart_tx_queue_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] level,
    output logic                   empty,
    output logic                   full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == (AW+1)'(DEPTH));
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_tx_queue.sv
// uart_tx_queue
//   Buffers bytes from a producer and drains them into the uart bus port:
//   polls LSR until THRE is set, writes the head byte to THR, then waits a
//   few settle cycles before polling again.
//   Ports:
//     clk, rst            : clock, asynchronous active-high reset
//     push_valid/data     : producer byte offer
//     push_ready          : byte accepted on this edge if push_valid
//     flush               : discard buffered bytes, abort polling
//     level/empty/full    : FIFO occupancy
//     busy                : FSM active or bytes still buffered
//     uart_addr/wen/wdata : bus drive towards the uart (decoded from state)
//     uart_rdata          : uart read data, valid one cycle after uart_addr
module uart_tx_queue
    import uart_tx_queue_pkg::*;
#(
    parameter int                  DEPTH      = 16,
    parameter logic [WORD_LEN-1:0] THR_ADDR   = UART_THR_ADDR,
    parameter logic [WORD_LEN-1:0] LSR_ADDR   = UART_LSR_ADDR,
    parameter int                  THRE_BIT   = LSR_THRE_BIT,
    parameter int                  SETTLE_CYC = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_valid,
    input  logic [7:0]             push_data,
    output logic                   push_ready,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] level,
    output logic                   empty,
    output logic                   full,
    output logic                   busy,
    output logic [WORD_LEN-1:0]    uart_addr,
    input  logic [WORD_LEN-1:0]    uart_rdata,
    output logic                   uart_wen,
    output logic [WORD_LEN-1:0]    uart_wdata
);

    localparam int CW = $clog2(SETTLE_CYC + 1);

    tx_state_e     state;
    tx_state_e     next_state;
    logic [CW-1:0] settle_cnt;
    logic [7:0]    head;
    logic          pop;
    logic          thre;
    logic          unused_rdata;

    // Only the THRE bit of the status word matters here.
    assign thre         = uart_rdata[THRE_BIT];
    assign unused_rdata = ^uart_rdata;

    assign push_ready = !rst && !full && !flush;
    assign pop        = (state == ST_WRITE);
    assign busy       = (state != ST_IDLE) || !empty;

    uart_tx_queue_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_valid && push_ready),
        .push_data (push_data),
        .pop       (pop),
        .flush     (flush),
        .head      (head),
        .level     (level),
        .empty     (empty),
        .full      (full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    // A flush in IDLE must not start polling for bytes that are being
    // discarded on the same edge.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (!empty && !flush) next_state = ST_POLL_A;
            ST_POLL_A: next_state = flush ? ST_IDLE : ST_POLL_C;
            ST_POLL_C: begin
                if (flush)              next_state = ST_IDLE;
                else if (thre && !empty) next_state = ST_WRITE;
                else                    next_state = ST_POLL_A;
            end
            ST_WRITE:  next_state = ST_SETTLE;
            ST_SETTLE: if (settle_cnt == '0) next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        uart_addr = LSR_ADDR;
        uart_wen  = 1'b0;
        if (state == ST_WRITE) begin
            uart_addr = THR_ADDR;
            uart_wen  = 1'b1;
        end
    end

    // Write data is captured only on entry to WRITE so it stays stable
    // between writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_cnt <= '0;
            uart_wdata <= '0;
        end else begin
            if (next_state == ST_WRITE)
                uart_wdata <= {{(WORD_LEN-8){1'b0}}, head};
            if (state == ST_WRITE)
                settle_cnt <= CW'(SETTLE_CYC - 1);
            else if (state == ST_SETTLE && settle_cnt != '0)
                settle_cnt <= settle_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue
//   Bench for uart_tx_queue. A small uart model answers LSR reads (THRE low
//   while a byte is "transmitting") and a queue model tracks which bytes
//   must appear on THR writes, in order.
module tb_uart_tx_queue;
    import uart_tx_queue_pkg::*;

    localparam int                  DEPTH      = 16;
    localparam int                  SETTLE_CYC = 2;
    localparam int                  THRE_BIT   = 5;
    localparam logic [WORD_LEN-1:0] THR_A      = 32'h0000_0000;
    localparam logic [WORD_LEN-1:0] LSR_A      = 32'h0000_0014;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                push_valid = 1'b0;
    logic [7:0]          push_data = 8'h00;
    logic                flush = 1'b0;
    logic                push_ready;
    logic [4:0]          level;
    logic                empty;
    logic                full;
    logic                busy;
    logic [WORD_LEN-1:0] uart_addr;
    logic [WORD_LEN-1:0] uart_rdata;
    logic                uart_wen;
    logic [WORD_LEN-1:0] uart_wdata;

    always #5 clk = ~clk;

    uart_tx_queue #(
        .DEPTH      (DEPTH),
        .THR_ADDR   (THR_A),
        .LSR_ADDR   (LSR_A),
        .THRE_BIT   (THRE_BIT),
        .SETTLE_CYC (SETTLE_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .push_valid (push_valid),
        .push_data  (push_data),
        .push_ready (push_ready),
        .flush      (flush),
        .level      (level),
        .empty      (empty),
        .full       (full),
        .busy       (busy),
        .uart_addr  (uart_addr),
        .uart_rdata (uart_rdata),
        .uart_wen   (uart_wen),
        .uart_wdata (uart_wdata)
    );

    // uart model: a THR write keeps THRE low for busy_len cycles; thre_en=0
    // forces THRE low. Read data is registered (one cycle latency).
    int busy_len = 0;
    bit thre_en  = 1'b1;
    int tx_cnt   = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_cnt     <= 0;
            uart_rdata <= '0;
        end else begin
            if (uart_wen && uart_addr == THR_A) tx_cnt <= busy_len;
            else if (tx_cnt > 0)                tx_cnt <= tx_cnt - 1;
            uart_rdata <= (uart_addr == LSR_A && thre_en && tx_cnt == 0 && !uart_wen)
                          ? (32'd1 << THRE_BIT) : 32'd0;
        end
    end

    // Reference model and counters
    logic [7:0] q[$];
    int n_cmp = 0;
    int n_bad = 0;
    bit prev_wen = 1'b0;
    bit last_accept = 1'b0;
    int writes = 0;
    int last_wr_cyc = 0;
    int cyc_n = 0;

    // Advance one clock: at the falling edge, apply the rising edge just
    // passed to the model, then compare the DUT against it.
    task automatic cyc();
        bit acc;
        @(negedge clk);
        cyc_n++;
        acc = push_valid && !flush && (q.size() < DEPTH);
        last_accept = acc;
        if (flush) q.delete();
        else begin
            if (prev_wen && q.size() > 0) void'(q.pop_front());
            if (acc) q.push_back(push_data);
        end
        n_cmp++;
        if (int'(level) !== q.size()) begin
            n_bad++; $display("FAIL level: got %0d expected %0d (cycle %0d)", level, q.size(), cyc_n);
        end
        n_cmp++;
        if (empty !== (q.size() == 0)) begin
            n_bad++; $display("FAIL empty: got %0b expected %0b", empty, q.size() == 0);
        end
        n_cmp++;
        if (full !== (q.size() == DEPTH)) begin
            n_bad++; $display("FAIL full: got %0b expected %0b", full, q.size() == DEPTH);
        end
        n_cmp++;
        if (push_ready !== (q.size() < DEPTH && !flush)) begin
            n_bad++; $display("FAIL push_ready: got %0b expected %0b", push_ready, q.size() < DEPTH && !flush);
        end
        if (uart_wen) begin
            n_cmp++;
            if (uart_addr !== THR_A) begin
                n_bad++; $display("FAIL write_addr: got %h expected %h", uart_addr, THR_A);
            end
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++; $display("FAIL unexpected_write: got wdata %h expected no write", uart_wdata);
            end else if (uart_wdata !== {24'h0, q[0]}) begin
                n_bad++; $display("FAIL write_data: got %h expected %h", uart_wdata, {24'h0, q[0]});
            end
            n_cmp++;
            if (prev_wen) begin
                n_bad++; $display("FAIL wen_double: got 2 consecutive expected 1");
            end
            n_cmp++;
            if (tx_cnt != 0) begin
                n_bad++; $display("FAIL write_while_thre_low: got tx_cnt %0d expected 0", tx_cnt);
            end
            if (writes > 0) begin
                n_cmp++;
                if (cyc_n - last_wr_cyc < 3 + SETTLE_CYC) begin
                    n_bad++; $display("FAIL write_gap: got %0d expected >= %0d", cyc_n - last_wr_cyc, 3 + SETTLE_CYC);
                end
            end
            writes++;
            last_wr_cyc = cyc_n;
        end else begin
            n_cmp++;
            if (uart_addr !== LSR_A) begin
                n_bad++; $display("FAIL idle_addr: got %h expected %h", uart_addr, LSR_A);
            end
        end
        prev_wen = uart_wen;
    endtask

    task automatic drain(input int bound, output bit ok);
        int n = 0;
        while ((q.size() != 0 || busy) && n < bound) begin
            cyc();
            n++;
        end
        ok = (n < bound);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        push_valid = 1'b1;
        push_data  = 8'hAA;
        @(negedge clk);
        n_cmp++; if (level !== 5'd0)     begin n_bad++; $display("FAIL rst_level: got %0d expected 0", level); end
        n_cmp++; if (empty !== 1'b1)     begin n_bad++; $display("FAIL rst_empty: got %0b expected 1", empty); end
        n_cmp++; if (full !== 1'b0)      begin n_bad++; $display("FAIL rst_full: got %0b expected 0", full); end
        n_cmp++; if (push_ready !== 1'b0) begin n_bad++; $display("FAIL rst_push_ready: got %0b expected 0", push_ready); end
        n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL rst_busy: got %0b expected 0", busy); end
        n_cmp++; if (uart_addr !== LSR_A) begin n_bad++; $display("FAIL rst_addr: got %h expected %h", uart_addr, LSR_A); end
        n_cmp++; if (uart_wen !== 1'b0)  begin n_bad++; $display("FAIL rst_wen: got %0b expected 0", uart_wen); end
        n_cmp++; if (uart_wdata !== 32'h0) begin n_bad++; $display("FAIL rst_wdata: got %h expected 0", uart_wdata); end
        push_valid = 1'b0;
        rst = 1'b0;
        q.delete();
        prev_wen = 1'b0;
        repeat (3) cyc();
    endtask

    task automatic test_single();
        int lat;
        int w0;
        thre_en  = 1'b1;
        busy_len = 0;
        w0 = writes;
        push_data  = 8'h41;
        push_valid = 1'b1;
        cyc();
        push_valid = 1'b0;
        lat = 1;
        while (!uart_wen && lat < 50) begin
            cyc();
            lat++;
        end
        n_cmp++;
        if (lat !== 4) begin n_bad++; $display("FAIL single_latency: got %0d expected 4", lat); end
        n_cmp++;
        if (uart_wdata !== 32'h41) begin n_bad++; $display("FAIL single_wdata: got %h expected 00000041", uart_wdata); end
        cyc();
        n_cmp++; if (level !== 5'd0) begin n_bad++; $display("FAIL single_level: got %0d expected 0", level); end
        n_cmp++; if (busy !== 1'b1)  begin n_bad++; $display("FAIL single_busy_settle: got %0b expected 1", busy); end
        repeat (SETTLE_CYC) cyc();
        n_cmp++; if (busy !== 1'b0)  begin n_bad++; $display("FAIL single_busy_fall: got %0b expected 0", busy); end
        n_cmp++; if (writes - w0 !== 1) begin n_bad++; $display("FAIL single_count: got %0d expected 1", writes - w0); end
    endtask

    task automatic test_thre_stall();
        int w0;
        bit ok;
        thre_en  = 1'b0;
        busy_len = 0;
        w0 = writes;
        push_data  = 8'h55;
        push_valid = 1'b1;
        cyc();
        push_valid = 1'b0;
        repeat (20) begin
            cyc();
            n_cmp++;
            if (uart_wen !== 1'b0) begin n_bad++; $display("FAIL stall_wen: got %0b expected 0", uart_wen); end
        end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL stall_busy: got %0b expected 1", busy); end
        thre_en = 1'b1;
        drain(40, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL stall_timeout: got busy %0b expected 0", busy); end
        n_cmp++; if (writes - w0 !== 1) begin n_bad++; $display("FAIL stall_count: got %0d expected 1", writes - w0); end
    endtask

    task automatic test_fill();
        int w0;
        int n;
        bit ok;
        thre_en  = 1'b0;
        busy_len = 0;
        w0 = writes;
        for (int i = 0; i <= 16; i++) begin
            push_data  = 8'(i);
            push_valid = 1'b1;
            cyc();
        end
        push_valid = 1'b0;
        n_cmp++; if (level !== 5'd16) begin n_bad++; $display("FAIL fill_level: got %0d expected 16", level); end
        n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL fill_full: got %0b expected 1", full); end
        n_cmp++; if (push_ready !== 1'b0) begin n_bad++; $display("FAIL fill_ready: got %0b expected 0", push_ready); end
        // Hold a push at full while the drain starts: it lands after the pop.
        push_data  = 8'hA0;
        push_valid = 1'b1;
        thre_en    = 1'b1;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!last_accept && n < 40);
        push_valid = 1'b0;
        n_cmp++; if (n >= 40) begin n_bad++; $display("FAIL simul_timeout: got %0d cycles expected < 40", n); end
        n_cmp++; if (level !== 5'd16) begin n_bad++; $display("FAIL simul_level: got %0d expected 16", level); end
        n_cmp++; if (writes - w0 !== 1) begin n_bad++; $display("FAIL simul_writes: got %0d expected 1", writes - w0); end
        drain(600, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL fill_timeout: got level %0d expected 0", level); end
        n_cmp++; if (writes - w0 !== 17) begin n_bad++; $display("FAIL fill_count: got %0d expected 17", writes - w0); end
    endtask

    task automatic test_flush();
        int w0;
        for (int t = 0; t < 2; t++) begin
            thre_en  = 1'b0;
            busy_len = 0;
            for (int i = 0; i < 5; i++) begin
                push_data  = 8'($urandom);
                push_valid = 1'b1;
                cyc();
            end
            push_valid = 1'b0;
            repeat (3 + t) cyc();
            n_cmp++; if (level !== 5'd5) begin n_bad++; $display("FAIL flush_pre_level: got %0d expected 5", level); end
            flush      = 1'b1;
            push_valid = 1'b1;
            push_data  = 8'($urandom);
            cyc();
            flush      = 1'b0;
            push_valid = 1'b0;
            n_cmp++; if (level !== 5'd0) begin n_bad++; $display("FAIL flush_level: got %0d expected 0", level); end
            n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL flush_busy: got %0b expected 0", busy); end
            thre_en = 1'b1;
            w0 = writes;
            repeat (15) cyc();
            n_cmp++; if (writes !== w0) begin n_bad++; $display("FAIL flush_writes: got %0d expected 0", writes - w0); end
        end
    endtask

    task automatic test_back_to_back();
        int w0;
        int acc_n;
        bit ok;
        thre_en  = 1'b1;
        busy_len = int'($urandom_range(4, 16));
        w0 = writes;
        acc_n = 0;
        for (int i = 0; i < 60; i++) begin
            push_valid = ($urandom % 10) < 7;
            push_data  = 8'($urandom);
            cyc();
            if (last_accept) acc_n++;
        end
        push_valid = 1'b0;
        drain(3000, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL b2b_timeout: got level %0d expected 0", level); end
        n_cmp++; if (writes - w0 !== acc_n) begin n_bad++; $display("FAIL b2b_count: got %0d expected %0d", writes - w0, acc_n); end
        busy_len = 0;
    endtask

    task automatic test_async_reset();
        int w0;
        int n;
        bit ok;
        thre_en  = 1'b1;
        busy_len = 0;
        push_valid = 1'b1;
        push_data  = 8'h5A;
        cyc();
        push_data  = 8'hC3;
        cyc();
        push_valid = 1'b0;
        n = 0;
        while (!uart_wen && n < 20) begin cyc(); n++; end
        n_cmp++; if (n >= 20) begin n_bad++; $display("FAIL arst_write_timeout: got %0d cycles expected < 20", n); end
        cyc();
        n_cmp++; if (level !== 5'd1 || busy !== 1'b1) begin
            n_bad++; $display("FAIL arst_pre: got level %0d busy %0b expected 1 1", level, busy);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (level !== 5'd0)      begin n_bad++; $display("FAIL arst_level: got %0d expected 0", level); end
        n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL arst_busy: got %0b expected 0", busy); end
        n_cmp++; if (push_ready !== 1'b0) begin n_bad++; $display("FAIL arst_ready: got %0b expected 0", push_ready); end
        n_cmp++; if (uart_wen !== 1'b0)   begin n_bad++; $display("FAIL arst_wen: got %0b expected 0", uart_wen); end
        n_cmp++; if (uart_addr !== LSR_A) begin n_bad++; $display("FAIL arst_addr: got %h expected %h", uart_addr, LSR_A); end
        n_cmp++; if (uart_wdata !== 32'h0) begin n_bad++; $display("FAIL arst_wdata: got %h expected 0", uart_wdata); end
        q.delete();
        prev_wen = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        w0 = writes;
        repeat (20) cyc();
        n_cmp++; if (writes !== w0) begin n_bad++; $display("FAIL arst_no_write: got %0d expected 0", writes - w0); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL arst_idle: got %0b expected 0", busy); end
        push_valid = 1'b1;
        push_data  = 8'h7E;
        cyc();
        push_valid = 1'b0;
        drain(40, ok);
        n_cmp++; if (!ok || writes - w0 !== 1) begin
            n_bad++; $display("FAIL arst_recover: got %0d writes expected 1", writes - w0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_thre_stall();
        test_fill();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
